branch_resolver: RTL and testbench
==================================

BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-low: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have rst_n input 1: synchronous active-low reset, sampled on the clk rising edge.
REQ-003 br_valid input 1: branch operands and comparator flags are valid this cycle.
REQ-004 br_ready output 1: resolver can accept a branch.
REQ-005 br_funct3 input 3: B-type funct3.
REQ-006 br_un output 1: unsigned-compare select driven to the comparator, equal to br_funct3[1], combinational.
REQ-007 br_eq, br_lt inputs 1 each: comparator equal and less-than flags.
REQ-008 br_pc input 32: branch PC; br_imm input 32: sign-extended B-immediate.
REQ-009 br_pred_taken input 1: fetch-stage prediction.
REQ-010 redir_valid output 1, redir_ready input 1, redir_pc output 32: fetch redirect handshake.
REQ-011 flush output 1: one-cycle pipeline flush pulse.
REQ-012 res_valid, res_taken, res_illegal, res_misalign outputs 1 each: resolution report.
REQ-013 stat_branches, stat_mispred outputs 32 each: performance counters.

Function
REQ-014 Taken condition: 000 br_eq; 001 !br_eq; 100/110 br_lt; 101/111 !br_lt; 010/011 are illegal, not taken, res_illegal=1.
REQ-015 Handshake: a branch is accepted on the clk edge where br_valid && br_ready; inputs are sampled only on that edge.
REQ-016 The FSM has states IDLE and REDIRECT; br_ready=1 only in IDLE.
REQ-017 On acceptance, next cycle: res_valid=1 for exactly one cycle, with res_taken/res_illegal/res_misalign registered, giving one-cycle latency.
REQ-018 Target = br_pc+br_imm modulo 2^32, wrapping with no overflow flag; fall-through = br_pc+4 modulo 2^32.
REQ-019 Mispredict = (taken != br_pred_taken); on mispredict redir_pc is registered to taken ? target : fall-through, and the FSM enters REDIRECT.
REQ-020 flush=1 for exactly the first cycle after a mispredicted acceptance.
REQ-021 res_misalign=1 when taken and target[1:0]!=0; the redirect still issues.
REQ-022 In REDIRECT: redir_valid=1 and redir_pc is held stable until the edge with redir_ready=1, then the FSM returns to IDLE with redir_valid=0 next cycle.
REQ-023 A br_valid asserted in the cycle redir_ready completes is not accepted, because br_ready=0; it is accepted no earlier than the following cycle.
REQ-024 A correctly predicted branch stays in IDLE and accepts back-to-back branches every cycle.
REQ-025 Illegal funct3 is treated as not taken; a mispredict is raised if br_pred_taken=1.

Reset
REQ-026 While rst_n=0 at the clk edge: FSM=IDLE; redir_valid, flush, res_* = 0; redir_pc=0; counters=0.
REQ-027 Reset asserted during REDIRECT abandons the redirect with no redir_valid afterwards; br_ready=1 on the first cycle after rst_n deasserts.

Configuration
REQ-028 With macro BRANCH_STATS_EN defined: stat_branches increments on each acceptance, stat_mispred on each mispredict, both saturating at 0xFFFFFFFF.
REQ-029 Without BRANCH_STATS_EN: no counter flops; stat_branches and stat_mispred are tied to 0; ports remain present.

Structure
REQ-030 Shared package riscv_branch_pkg SHALL hold the funct3 enum (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the resolver FSM state enum.
REQ-031 One combinational sub-module branch_cond_eval (funct3, eq, lt -> taken, illegal); the FSM, target adders and counters live in branch_resolver.

Verification
REQ-032 BEQ, eq=1, pred=0, pc=0x100, imm=0x20 -> next cycle: flush=1, redir_valid=1, redir_pc=0x120, res_taken=1.
REQ-033 BGEU, lt=0, pred=1 -> no flush, no redirect, br_ready stays 1; a back-to-back second branch is accepted in the next cycle.
REQ-034 BLT mispredict with redir_ready=0 for 3 cycles -> redir_pc stable, br_ready=0 for 3 cycles, IDLE one cycle after redir_ready=1.
REQ-035 pc=0xFFFFFFFC, BNE not taken, pred=1 -> redir_pc=0x00000000 (wrap); funct3=010, pred=0 -> res_illegal=1, no redirect.
REQ-036 rst_n=0 during REDIRECT -> redir_valid=0 and counters=0 next cycle; with BRANCH_STATS_EN, 5 branches including 2 mispredicts -> stat_branches=5, stat_mispred=2.

Source files
------------

// File: rtl/riscv_branch_pkg.sv
// Shared RISC-V branch definitions: B-type funct3 encodings and the resolver FSM states.
package riscv_branch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INSN_LEN = 32'd4;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } funct3_e;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_REDIRECT = 1'b1
    } res_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational taken/illegal decode of a B-type funct3 from the comparator flags.
module branch_cond_eval
    import riscv_branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       eq,
    input  logic       lt,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            BEQ:        taken = eq;
            BNE:        taken = !eq;
            BLT, BLTU:  taken = lt;
            BGE, BGEU:  taken = !lt;
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: evaluates branches, reports results, issues fetch redirects on mispredict.
// Optional performance counters are built when BRANCH_STATS_EN is defined.
module branch_resolver
    import riscv_branch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_valid,
    output logic        br_ready,
    input  logic [2:0]  br_funct3,
    output logic        br_un,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic        br_pred_taken,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        res_valid,
    output logic        res_taken,
    output logic        res_illegal,
    output logic        res_misalign,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);

    res_state_e  state;
    logic        taken, illegal, accept, mispred;
    logic [31:0] target, fall_thru;

    branch_cond_eval u_cond (
        .funct3  (br_funct3),
        .eq      (br_eq),
        .lt      (br_lt),
        .taken   (taken),
        .illegal (illegal)
    );

    assign br_un     = br_funct3[1];
    assign br_ready  = (state == S_IDLE);
    assign accept    = br_valid && br_ready;
    assign target    = br_pc + br_imm;
    assign fall_thru = br_pc + INSN_LEN;
    assign mispred   = (taken != br_pred_taken);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            redir_valid  <= 1'b0;
            redir_pc     <= '0;
            flush        <= 1'b0;
            res_valid    <= 1'b0;
            res_taken    <= 1'b0;
            res_illegal  <= 1'b0;
            res_misalign <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            flush     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        res_valid    <= 1'b1;
                        res_taken    <= taken;
                        res_illegal  <= illegal;
                        res_misalign <= taken && (target[1:0] != 2'b00);
                        if (mispred) begin
                            flush       <= 1'b1;
                            redir_valid <= 1'b1;
                            redir_pc    <= taken ? target : fall_thru;
                            state       <= S_REDIRECT;
                        end
                    end
                end
                S_REDIRECT: begin
                    // redir_pc stays put until fetch takes it
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] cnt_br, cnt_mp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_br <= '0;
            cnt_mp <= '0;
        end else if (accept) begin
            if (cnt_br != 32'hFFFF_FFFF) cnt_br <= cnt_br + 32'd1;
            if (mispred && cnt_mp != 32'hFFFF_FFFF) cnt_mp <= cnt_mp + 32'd1;
        end
    end

    assign stat_branches = cnt_br;
    assign stat_mispred  = cnt_mp;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized bench for branch_resolver against a transaction-level reference model.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        br_valid, br_ready;
    logic [2:0]  br_funct3;
    logic        br_un, br_eq, br_lt;
    logic [31:0] br_pc, br_imm;
    logic        br_pred_taken;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;
    logic        flush, res_valid, res_taken, res_illegal, res_misalign;
    logic [31:0] stat_branches, stat_mispred;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit          m_busy;
    logic [31:0] m_rpc;
    bit          m_rvalid, m_flush, m_taken, m_ill, m_mis;
    longint      m_nbr, m_nmp;

    always #5 clk = ~clk;

    branch_resolver dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_funct3     (br_funct3),
        .br_un         (br_un),
        .br_eq         (br_eq),
        .br_lt         (br_lt),
        .br_pc         (br_pc),
        .br_imm        (br_imm),
        .br_pred_taken (br_pred_taken),
        .redir_valid   (redir_valid),
        .redir_ready   (redir_ready),
        .redir_pc      (redir_pc),
        .flush         (flush),
        .res_valid     (res_valid),
        .res_taken     (res_taken),
        .res_illegal   (res_illegal),
        .res_misalign  (res_misalign),
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    // Apply one cycle of inputs, advance the model at the edge, then check outputs.
    task automatic step(input logic v, input logic [2:0] f3, input logic eq, input logic lt,
                        input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                        input logic rr, input logic rs);
        bit          t, ill;
        logic [31:0] tgt;
        br_valid = v; br_funct3 = f3; br_eq = eq; br_lt = lt; br_pc = pc; br_imm = imm;
        br_pred_taken = pred; redir_ready = rr; rst_n = rs;
        #1;
        chk("br_un", {31'd0, br_un}, {31'd0, f3[1]});
        @(posedge clk);
        t = 0; ill = 0;
        case (f3)
            3'd0: t = eq;
            3'd1: t = !eq;
            3'd4, 3'd6: t = lt;
            3'd5, 3'd7: t = !lt;
            default: ill = 1;
        endcase
        tgt = pc + imm;
        m_rvalid = 0;
        m_flush  = 0;
        if (!rs) begin
            m_busy = 0; m_rpc = 0; m_nbr = 0; m_nmp = 0;
        end else if (m_busy) begin
            if (rr) m_busy = 0;
        end else if (v) begin
            m_rvalid = 1; m_taken = t; m_ill = ill;
            m_mis = t && (tgt[1:0] != 2'b00);
            m_nbr++;
            if (t != pred) begin
                m_nmp++;
                m_busy  = 1;
                m_flush = 1;
                m_rpc   = t ? tgt : pc + 32'd4;
            end
        end
        @(negedge clk);
        chk("res_valid", {31'd0, res_valid}, {31'd0, m_rvalid});
        if (m_rvalid) begin
            chk("res_taken",    {31'd0, res_taken},    {31'd0, m_taken});
            chk("res_illegal",  {31'd0, res_illegal},  {31'd0, m_ill});
            chk("res_misalign", {31'd0, res_misalign}, {31'd0, m_mis});
        end
        chk("flush",       {31'd0, flush},       {31'd0, m_flush});
        chk("redir_valid", {31'd0, redir_valid}, {31'd0, m_busy});
        chk("br_ready",    {31'd0, br_ready},    {31'd0, !m_busy});
        if (m_busy || !rs) chk("redir_pc", redir_pc, m_rpc);
`ifdef BRANCH_STATS_EN
        chk("stat_branches", stat_branches, sat(m_nbr));
        chk("stat_mispred",  stat_mispred,  sat(m_nmp));
`else
        chk("stat_branches", stat_branches, 32'd0);
        chk("stat_mispred",  stat_mispred,  32'd0);
`endif
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, rr, 1'b1);
    endtask

    initial begin
        logic [31:0] held;
        m_busy = 0; m_rpc = 0; m_nbr = 0; m_nmp = 0;
        m_rvalid = 0; m_flush = 0; m_taken = 0; m_ill = 0; m_mis = 0;
        @(negedge clk);
        step(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_redir_pc", redir_pc, 32'd0);

        // BEQ taken, predicted not taken -> redirect to pc+imm
        step(1'b1, 3'b000, 1'b1, 1'b0, 32'h100, 32'h20, 1'b0, 1'b0, 1'b1);
        chk("beq_pc", redir_pc, 32'h120);
        chk("beq_flush", {31'd0, flush}, 32'd1);
        idle(1'b1);

        // correctly predicted BGEU back to back
        step(1'b1, 3'b111, 1'b0, 1'b0, 32'h200, 32'h40, 1'b1, 1'b0, 1'b1);
        chk("bgeu_ready", {31'd0, br_ready}, 32'd1);
        step(1'b1, 3'b111, 1'b0, 1'b0, 32'h204, 32'h40, 1'b1, 1'b0, 1'b1);
        chk("bgeu_b2b", {31'd0, res_valid}, 32'd1);

        // BLT mispredict with fetch stalled; new branch offered while busy
        step(1'b1, 3'b100, 1'b0, 1'b1, 32'h300, 32'h10, 1'b0, 1'b0, 1'b1);
        held = redir_pc;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b000, 1'b1, 1'b0, 32'h400, 32'h8, 1'b0, 1'b0, 1'b1);
            chk("blt_hold", redir_pc, held);
        end
        step(1'b1, 3'b000, 1'b1, 1'b0, 32'h400, 32'h8, 1'b0, 1'b1, 1'b1);
        chk("blt_idle", {31'd0, br_ready}, 32'd1);
        idle(1'b0);

        // fall-through wraps at the top of the address space
        step(1'b1, 3'b001, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 1'b1);
        chk("wrap_pc", redir_pc, 32'h0000_0000);
        idle(1'b1);
        // illegal funct3, predicted not taken -> no redirect
        step(1'b1, 3'b010, 1'b1, 1'b1, 32'h500, 32'h8, 1'b0, 1'b0, 1'b1);
        chk("ill_flag", {31'd0, res_illegal}, 32'd1);
        // taken to a misaligned target still redirects
        step(1'b1, 3'b000, 1'b1, 1'b0, 32'h600, 32'h6, 1'b0, 1'b0, 1'b1);
        chk("mis_flag", {31'd0, res_misalign}, 32'd1);

        // reset while redirect pending
        step(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_rv", {31'd0, redir_valid}, 32'd0);
        chk("rst_cnt", stat_branches, 32'd0);
        idle(1'b0);

        // five branches, two of them mispredicted
        step(1'b1, 3'b000, 1'b1, 1'b0, 32'h700, 32'h8, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'b001, 1'b1, 1'b0, 32'h704, 32'h8, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, 3'b101, 1'b0, 1'b0, 32'h708, 32'h8, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3'b110, 1'b0, 1'b1, 32'h70C, 32'h8, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        step(1'b1, 3'b100, 1'b0, 1'b0, 32'h710, 32'h8, 1'b0, 1'b0, 1'b1);
`ifdef BRANCH_STATS_EN
        chk("stat5", stat_branches, 32'd5);
        chk("stat2", stat_mispred,  32'd2);
`endif

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] imm;
            imm = $urandom;
            if ($urandom_range(3) != 0) imm[1:0] = 2'b00;
            step($urandom_range(3) != 0, 3'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : $urandom, imm,
                 1'($urandom), $urandom_range(2) != 0, $urandom_range(99) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
